raw_frame_seq: RTL and testbench

RAW_FRAME_SEQ -- requirements
Module: raw_frame_seq

---
 rtl/raw_pkg.sv | 17 +
 rtl/line_counter.sv | 86 ++++++++
 rtl/raw_frame_seq.sv | 131 +++++++++++++
 tb/tb_raw_frame_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_pkg.sv
// Shared types for the raw Bayer frame sequencer: FSM state encoding and
// the common counter width used for column, row and frame counters.
package raw_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    WAIT_FRAME,
    ACTIVE,
    DONE
  } state_t;

endpackage

// File: rtl/line_counter.sv
// Pixel position tracking for one frame: column and row counters plus the
// per-pixel overflow flag and the per-line short-line flag. Counting is only
// enabled while the sequencer is capturing; otherwise everything is held at 0.
module line_counter
  import raw_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 960
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic fval_i,
  input  logic lval_i,
  input  logic dval_i,
  output cnt_t col_o,
  output cnt_t row_o,
  output logic pix_ok_o,
  output logic overflow_o,
  output logic short_o
);

  localparam cnt_t WIDTH_C  = cnt_t'(IMG_WIDTH);
  localparam cnt_t HEIGHT_C = cnt_t'(IMG_HEIGHT);

  cnt_t col_q, col_d;
  cnt_t row_q, row_d;
  logic line_q, line_d;
  logic has_pix_q, has_pix_d;

  logic line_now, accept, line_close, col_full, row_full;

  // A line is "open" only while the frame is open too, so a frame that drops
  // together with (or before) its line closes that line first.
  assign line_now   = fval_i & lval_i;
  assign accept     = en_i & line_now & dval_i;
  assign line_close = en_i & line_q & ~line_now;
  assign col_full   = (col_q >= WIDTH_C);
  assign row_full   = (row_q >= HEIGHT_C);

  assign pix_ok_o   = accept & ~col_full & ~row_full;
  assign overflow_o = accept & (col_full | row_full);
  // Lines that never delivered a pixel are not lines at all (no row, no error).
  assign short_o    = line_close & has_pix_q & (col_q < WIDTH_C);

  assign col_o = col_q;
  assign row_o = row_q;

  // Next-state for the position counters; column saturates at the width so
  // overflow pixels keep being flagged, row saturates at the counter maximum.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    has_pix_d = has_pix_q;
    line_d    = line_now;
    if (!en_i) begin
      col_d     = '0;
      row_d     = '0;
      has_pix_d = 1'b0;
      line_d    = 1'b0;
    end else if (line_close) begin
      col_d     = '0;
      has_pix_d = 1'b0;
      if (has_pix_q && (row_q != '1)) row_d = row_q + 1'b1;
    end else if (accept) begin
      has_pix_d = 1'b1;
      if (!col_full) col_d = col_q + 1'b1;
    end
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      line_q    <= 1'b0;
      has_pix_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      line_q    <= line_d;
      has_pix_q <= has_pix_d;
    end
  end

endmodule

// File: rtl/raw_frame_seq.sv
// Raw sensor frame sequencer: arms on start (or automatically with cont),
// waits for a clean frame boundary, forwards one frame of pixels with their
// coordinates and flags geometry errors in a sticky oErr.
module raw_frame_seq
  import raw_pkg::*;
#(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 960
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  input  logic        start,
  input  logic        cont,
  output logic [11:0] oPixel,
  output logic        oPixel_valid,
  output logic [15:0] oCol,
  output logic [15:0] oRow,
  output logic        oFrame_start,
  output logic        oFrame_done,
  output logic        oErr,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output state_t      dbg_state_o
);

  localparam cnt_t HEIGHT_C = cnt_t'(IMG_HEIGHT);

  state_t state_q, state_d;
  logic   done_prev_q;
  logic   err_q, err_d;

  logic [11:0] pixel_q;
  logic        valid_q, fstart_q, done_q;
  cnt_t        col_q, row_q, frame_cnt_q;

  cnt_t lc_col, lc_row;
  logic lc_pix_ok, lc_overflow, lc_short;

  line_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_line_counter (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == ACTIVE),
    .fval_i    (iFVAL),
    .lval_i    (iLVAL),
    .dval_i    (iDVAL),
    .col_o     (lc_col),
    .row_o     (lc_row),
    .pix_ok_o  (lc_pix_ok),
    .overflow_o(lc_overflow),
    .short_o   (lc_short)
  );

  // Next-state logic; start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start || (cont && done_prev_q)) state_d = SYNC;
      SYNC:       if (!iFVAL) state_d = WAIT_FRAME;
      WAIT_FRAME: if (iFVAL) state_d = ACTIVE;
      ACTIVE:     if (!iFVAL) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Sticky error: cleared when start arms a capture, set by any geometry fault.
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && start) begin
      err_d = 1'b0;
    end else if (lc_overflow || lc_short ||
                 ((state_q == DONE) && (lc_row != HEIGHT_C))) begin
      err_d = 1'b1;
    end
  end

  // State register and the one-cycle memory of oFrame_done for cont re-arming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= done_q;
    end
  end

  // Output registers: pixel path, frame pulses, error flag and frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_q     <= '0;
      valid_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      fstart_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      valid_q  <= lc_pix_ok;
      fstart_q <= lc_pix_ok && (lc_col == '0) && (lc_row == '0);
      done_q   <= (state_d == DONE);
      err_q    <= err_d;
      if (lc_pix_ok) begin
        pixel_q <= iDATA;
        col_q   <= lc_col;
        row_q   <= lc_row;
      end
      if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign oPixel       = pixel_q;
  assign oPixel_valid = valid_q;
  assign oCol         = col_q;
  assign oRow         = row_q;
  assign oFrame_start = fstart_q;
  assign oFrame_done  = done_q;
  assign oErr         = err_q;
  assign busy         = (state_q != IDLE);
  assign frame_cnt    = frame_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_raw_frame_seq.sv
// Bench for raw_frame_seq on a reduced 8x5 geometry. Frames are described as
// per-line pixel counts; the expected pixel stream and error flag are derived
// from those counts, and a negedge monitor checks every output pixel.
module tb_raw_frame_seq;
  import raw_pkg::*;

  localparam int W = 8;
  localparam int H = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iFVAL = 1'b0, iLVAL = 1'b0, iDVAL = 1'b0;
  logic [11:0] iDATA = '0;
  logic        start = 1'b0, cont = 1'b0;
  logic [11:0] oPixel;
  logic        oPixel_valid, oFrame_start, oFrame_done, oErr, busy;
  logic [15:0] oCol, oRow, frame_cnt;
  state_t      dbg_state;

  int n_assert = 0;
  int n_fail = 0;
  int done_seen = 0;
  int exp_done = 0;
  int exp_frames = 0;
  logic [43:0] exp_q[$];
  logic [43:0] mon_e;
  int line_len[16];
  bit m_err;
  bit m_abort;

  raw_frame_seq #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .iFVAL(iFVAL), .iLVAL(iLVAL), .iDVAL(iDVAL),
    .iDATA(iDATA), .start(start), .cont(cont), .oPixel(oPixel),
    .oPixel_valid(oPixel_valid), .oCol(oCol), .oRow(oRow),
    .oFrame_start(oFrame_start), .oFrame_done(oFrame_done), .oErr(oErr),
    .busy(busy), .frame_cnt(frame_cnt), .dbg_state_o(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard monitor: every valid pixel must match the head of exp_q
  always @(negedge clk) begin
    if (rst) begin
      if (oFrame_done) done_seen++;
      if (oPixel_valid) begin
        n_assert++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL pix_unexpected: got row=%0d col=%0d data=%h, expected no pixel", oRow, oCol, oPixel);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          n_assert++;
          assert ({oRow, oCol, oPixel} === mon_e) else begin
            n_fail++;
            $error("FAIL pix_value: got row=%0d col=%0d data=%h, expected row=%0d col=%0d data=%h",
                   oRow, oCol, oPixel, mon_e[43:28], mon_e[27:12], mon_e[11:0]);
          end
          n_assert++;
          assert (oFrame_start === (mon_e[43:12] == 32'd0)) else begin
            n_fail++;
            $error("FAIL frame_start: got %b at row=%0d col=%0d", oFrame_start, oRow, oCol);
          end
        end
      end else begin
        n_assert++;
        assert (oFrame_start === 1'b0) else begin
          n_fail++;
          $error("FAIL frame_start_idle: got %b, expected 0 without a pixel", oFrame_start);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      iLVAL = 1'b0; iDVAL = 1'b0; start = 1'b0;
    end
  endtask

  task automatic set_lines(input int len);
    for (int i = 0; i < 16; i++) line_len[i] = len;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idle(3);
    n_assert++;
    assert (busy === 1'b1) else begin
      n_fail++;
      $error("FAIL busy_after_start: got %b, expected 1", busy);
    end
  endtask

  task automatic check_frame(input bit exp_err, input bit exp_busy, input string tag);
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_missing: %0d expected pixels never appeared, expected 0", tag, exp_q.size());
    end
    exp_q.delete();
    n_assert++;
    assert (done_seen === exp_done) else begin
      n_fail++;
      $error("FAIL %s_done: got %0d frame_done pulses, expected %0d", tag, done_seen, exp_done);
    end
    n_assert++;
    assert (frame_cnt === 16'(exp_frames)) else begin
      n_fail++;
      $error("FAIL %s_frame_cnt: got %0d, expected %0d", tag, frame_cnt, exp_frames);
    end
    n_assert++;
    assert (oErr === exp_err) else begin
      n_fail++;
      $error("FAIL %s_err: got %b, expected %b", tag, oErr, exp_err);
    end
    n_assert++;
    assert (busy === exp_busy) else begin
      n_fail++;
      $error("FAIL %s_busy: got %b, expected %b", tag, busy, exp_busy);
    end
  endtask

  task automatic reset_mid_frame();
    #2 rst = 1'b0;
    #1;
    n_assert++;
    assert ({oPixel_valid, oPixel, oCol, oRow, oFrame_start, oFrame_done, oErr, busy, frame_cnt} === '0) else begin
      n_fail++;
      $error("FAIL async_reset: got valid=%b pix=%h col=%0d row=%0d fs=%b fd=%b err=%b busy=%b fcnt=%0d, expected all 0",
             oPixel_valid, oPixel, oCol, oRow, oFrame_start, oFrame_done, oErr, busy, frame_cnt);
    end
    exp_q.delete();
    exp_frames = 0;
    iFVAL = 1'b0; iLVAL = 1'b0; iDVAL = 1'b0; start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    idle(3);
    n_assert++;
    assert (done_seen === exp_done && busy === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_abort: got done=%0d busy=%b, expected done=%0d busy=0", done_seen, busy, exp_done);
    end
  endtask

  // One frame of nl lines with lengths from line_len. Optional: cut the frame
  // at (cut_line, cut_col), pulse start at the beginning of start_line, or
  // reset after two pixels of rst_line. Pixels are expected only when capture.
  task automatic drive_frame(input int nl, input int cut_line, input int cut_col,
                             input int start_line, input int rst_line,
                             input bit rand_dval, input bit capture);
    int  nonempty;
    bit  err;
    bit  stop;
    nonempty = 0; err = 1'b0; stop = 1'b0; m_abort = 1'b0;
    @(posedge clk); #1 iFVAL = 1'b1;
    idle(2);
    for (int l = 0; l < nl && !stop; l++) begin
      int acc;
      bit first;
      acc = 0; first = 1'b1;
      while (acc < line_len[l] && !stop) begin
        if (l == cut_line && acc == cut_col) begin
          stop = 1'b1;
        end else if (l == rst_line && acc == 2) begin
          reset_mid_frame();
          stop = 1'b1;
          m_abort = 1'b1;
        end else begin
          @(posedge clk); #1;
          iLVAL = 1'b1;
          iDVAL = rand_dval ? 1'($urandom_range(0, 1)) : 1'b1;
          iDATA = 12'($urandom);
          start = (l == start_line) && first;
          first = 1'b0;
          if (iDVAL) begin
            if (capture && acc < W && nonempty < H)
              exp_q.push_back({16'(nonempty), 16'(acc), iDATA});
            acc++;
          end
        end
      end
      if (acc > 0) begin
        nonempty++;
        if (acc != W) err = 1'b1;
      end
      if (!stop) idle(2);
    end
    if (nonempty != H) err = 1'b1;
    m_err = err;
    if (!m_abort) begin
      @(posedge clk); #1;
      iFVAL = 1'b0; iLVAL = 1'b0; iDVAL = 1'b0; start = 1'b0;
      idle(6);
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    assert ({oPixel_valid, oPixel, oCol, oRow, oFrame_start, oFrame_done, oErr, busy, frame_cnt} === '0) else begin
      n_fail++;
      $error("FAIL reset_state: got valid=%b err=%b busy=%b fcnt=%0d, expected all 0",
             oPixel_valid, oErr, busy, frame_cnt);
    end
    @(posedge clk); #1 rst = 1'b1;
    idle(2);

    // full clean frame
    set_lines(W);
    do_start();
    drive_frame(H, -1, -1, -1, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "clean");

    // long line 1; a start pulse during capture must be ignored
    set_lines(W);
    line_len[1] = W + 2;
    do_start();
    drive_frame(H, -1, -1, 3, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "long_line");

    // start while a frame is already running: that frame is skipped
    set_lines(W);
    drive_frame(H, -1, -1, 2, -1, 1'b0, 1'b0);
    check_frame(1'b0, 1'b1, "mid_start");
    drive_frame(H, -1, -1, -1, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "after_mid");

    // frame cut off inside row 2, line and frame valid fall together
    set_lines(W);
    do_start();
    drive_frame(H, 2, 4, -1, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "cut");

    // one line too many
    set_lines(W);
    do_start();
    drive_frame(H + 1, -1, -1, -1, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "extra_line");

    // short line in the middle of the frame
    set_lines(W);
    line_len[2] = W - 3;
    do_start();
    drive_frame(H, -1, -1, -1, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "short_line");

    // continuous mode over three frames with gappy data valid
    set_lines(W);
    cont = 1'b1;
    do_start();
    drive_frame(H, -1, -1, -1, -1, 1'b1, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b1, "cont1");
    drive_frame(H, -1, -1, -1, -1, 1'b1, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b1, "cont2");
    cont = 1'b0;
    drive_frame(H, -1, -1, -1, -1, 1'b1, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "cont3");

    // reset in row 3, then a normal capture
    set_lines(W);
    do_start();
    drive_frame(H, -1, -1, -1, 3, 1'b0, 1'b1);
    do_start();
    drive_frame(H, -1, -1, -1, -1, 1'b0, 1'b1);
    exp_done++; exp_frames++;
    check_frame(m_err, 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
